// File: rtl/warp_ibuffer.sv
// warp_ibuffer: per-warp instruction FIFOs sitting between fetch and decode/issue.
// Each warp owns DEPTH {pc, instr} entries. The buffer reports a ready mask back
// to fetch, presents the selected warp's head entry combinationally, supports
// per-warp flush on branch redirect, and keeps sticky overflow/underflow flags.
// Optional feature macro: IBUF_BYPASS_EN. When defined, an enqueue into an empty
// warp that is also the selected deq_warp is forwarded straight to the head
// outputs in the same cycle.
module warp_ibuffer #(
    parameter int NUM_WARPS   = 4,
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] enq_warp,
    input  logic [PC_WIDTH-1:0]          enq_pc,
    input  logic [INSTR_WIDTH-1:0]       enq_instr,
    output logic [NUM_WARPS-1:0]         ready_mask,
    input  logic [$clog2(NUM_WARPS)-1:0] deq_warp,
    input  logic                         deq_en,
    output logic [NUM_WARPS-1:0]         head_valid_mask,
    output logic [PC_WIDTH-1:0]          head_pc,
    output logic [INSTR_WIDTH-1:0]       head_instr,
    input  logic                         flush_en,
    input  logic [$clog2(NUM_WARPS)-1:0] flush_warp,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int WW      = $clog2(NUM_WARPS);
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRIES = NUM_WARPS * DEPTH;

    // Shared storage: warp ID forms the upper address bits, pointer the lower.
    logic [PC_WIDTH-1:0]    pc_mem    [ENTRIES];
    logic [INSTR_WIDTH-1:0] instr_mem [ENTRIES];

    logic [NUM_WARPS-1:0][PW-1:0] rd_ptr_w;
    logic [NUM_WARPS-1:0][PW-1:0] wr_ptr_w;
    logic [NUM_WARPS-1:0]         bypass_w;
    logic [NUM_WARPS-1:0]         ovf_set_w;
    logic [NUM_WARPS-1:0]         udf_set_w;
    logic [NUM_WARPS-1:0]         mem_we_w;

    logic overflow_reg;
    logic underflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
            logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
            logic [CW-1:0] count_reg, count_next;
            logic          bypass_l, ovf_l, udf_l, we_l;

            // Per-warp next-state: flush wins, then independent enqueue/dequeue.
            always_comb begin
                logic enq_hit, deq_hit, flush_hit, empty, full, do_enq, do_deq;
                enq_hit   = enq_valid && (enq_warp == WW'(gi));
                deq_hit   = deq_en && (deq_warp == WW'(gi));
                flush_hit = flush_en && (flush_warp == WW'(gi));
                empty     = (count_reg == '0);
                full      = (count_reg == CW'(DEPTH));
                bypass_l  = 1'b0;
`ifdef IBUF_BYPASS_EN
                // Enqueue into an empty, currently selected warp is visible at once.
                bypass_l  = enq_hit && (deq_warp == WW'(gi)) && empty && !flush_hit;
`endif
                do_enq    = enq_hit && !flush_hit && !full;
                do_deq    = deq_hit && !flush_hit && (!empty || bypass_l);
                ovf_l     = enq_hit && !flush_hit && full;
                udf_l     = deq_hit && !flush_hit && empty && !bypass_l;
                // A bypassed entry consumed in the same cycle never needs storing.
                we_l      = do_enq && !(bypass_l && deq_hit);

                rd_ptr_next = rd_ptr_reg;
                wr_ptr_next = wr_ptr_reg;
                count_next  = count_reg;
                if (flush_hit) begin
                    rd_ptr_next = '0;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end else begin
                    if (do_enq) wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (do_deq) rd_ptr_next = rd_ptr_reg + 1'b1;
                    if (do_enq && !do_deq)      count_next = count_reg + 1'b1;
                    else if (!do_enq && do_deq) count_next = count_reg - 1'b1;
                end
            end

            // Pointer and occupancy registers for this warp.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    rd_ptr_reg <= rd_ptr_next;
                    wr_ptr_reg <= wr_ptr_next;
                    count_reg  <= count_next;
                end
            end

            assign rd_ptr_w[gi]  = rd_ptr_reg;
            assign wr_ptr_w[gi]  = wr_ptr_reg;
            assign bypass_w[gi]  = bypass_l;
            assign ovf_set_w[gi] = ovf_l;
            assign udf_set_w[gi] = udf_l;
            assign mem_we_w[gi]  = we_l;
            // Two free slots: room for the fetch already in flight when this drops.
            assign ready_mask[gi]      = (count_reg <= CW'(DEPTH - 2));
            assign head_valid_mask[gi] = (count_reg != '0) || bypass_l;
        end
    endgenerate

    logic [WW+PW-1:0] wr_addr;
    logic [WW+PW-1:0] rd_addr;
    assign wr_addr = {enq_warp, wr_ptr_w[enq_warp]};
    assign rd_addr = {deq_warp, rd_ptr_w[deq_warp]};

    // Entry storage write; data is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (|mem_we_w) begin
            pc_mem[wr_addr]    <= enq_pc;
            instr_mem[wr_addr] <= enq_instr;
        end
    end

    // Head of the selected warp, read combinationally for decode/issue.
    always_comb begin
        head_pc    = pc_mem[rd_addr];
        head_instr = instr_mem[rd_addr];
        if (bypass_w[deq_warp]) begin
            head_pc    = enq_pc;
            head_instr = enq_instr;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg | (|ovf_set_w);
            underflow_reg <= underflow_reg | (|udf_set_w);
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_warp_ibuffer.sv
// Scoreboard bench for warp_ibuffer: directed stimulus pushes expected output
// snapshots into a queue; a monitor pops and compares them on the falling edge.
module tb_warp_ibuffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic [1:0]  enq_warp;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic [3:0]  ready_mask;
    logic [1:0]  deq_warp;
    logic        deq_en;
    logic [3:0]  head_valid_mask;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic        flush_en;
    logic [1:0]  flush_warp;
    logic        overflow;
    logic        underflow;

    localparam logic [4:0] C_RM  = 5'b00001;
    localparam logic [4:0] C_HV  = 5'b00010;
    localparam logic [4:0] C_PC  = 5'b00100;
    localparam logic [4:0] C_OVF = 5'b01000;
    localparam logic [4:0] C_UDF = 5'b10000;

    typedef struct {
        string       name;
        logic [4:0]  care;
        logic [3:0]  rm;
        logic [3:0]  hv;
        logic [31:0] pc;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;

    warp_ibuffer #(.NUM_WARPS(4), .DEPTH(4), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_warp(enq_warp), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .ready_mask(ready_mask),
        .deq_warp(deq_warp), .deq_en(deq_en),
        .head_valid_mask(head_valid_mask), .head_pc(head_pc), .head_instr(head_instr),
        .flush_en(flush_en), .flush_warp(flush_warp),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.care[0]) begin
                nvec++;
                if (ready_mask !== e.rm) begin
                    nfail++;
                    $display("FAIL %s ready_mask got %b want %b", e.name, ready_mask, e.rm);
                end
            end
            if (e.care[1]) begin
                nvec++;
                if (head_valid_mask !== e.hv) begin
                    nfail++;
                    $display("FAIL %s head_valid_mask got %b want %b", e.name, head_valid_mask, e.hv);
                end
            end
            if (e.care[2]) begin
                nvec += 2;
                if (head_pc !== e.pc) begin
                    nfail++;
                    $display("FAIL %s head_pc got %h want %h", e.name, head_pc, e.pc);
                end
                if (head_instr !== (e.pc ^ 32'hC0DE_0000)) begin
                    nfail++;
                    $display("FAIL %s head_instr got %h want %h", e.name, head_instr, e.pc ^ 32'hC0DE_0000);
                end
            end
            if (e.care[3]) begin
                nvec++;
                if (overflow !== e.ovf) begin
                    nfail++;
                    $display("FAIL %s overflow got %b want %b", e.name, overflow, e.ovf);
                end
            end
            if (e.care[4]) begin
                nvec++;
                if (underflow !== e.udf) begin
                    nfail++;
                    $display("FAIL %s underflow got %b want %b", e.name, underflow, e.udf);
                end
            end
            $display("check %s done", e.name);
        end
    end

    task automatic chk(input string name, input logic [4:0] care, input logic [3:0] rm,
                       input logic [3:0] hv, input logic [31:0] pc, input logic ovf, input logic udf);
        exp_t e;
        e.name = name; e.care = care; e.rm = rm; e.hv = hv; e.pc = pc; e.ovf = ovf; e.udf = udf;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        deq_en    = 1'b0;
        flush_en  = 1'b0;
    endtask

    task automatic enq(input logic [1:0] w, input logic [31:0] pc);
        enq_valid = 1'b1;
        enq_warp  = w;
        enq_pc    = pc;
        enq_instr = pc ^ 32'hC0DE_0000;
    endtask

    task automatic deq(input logic [1:0] w);
        deq_en   = 1'b1;
        deq_warp = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        enq_warp = 2'd0; enq_pc = '0; enq_instr = '0; deq_warp = 2'd0; flush_warp = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_state", C_RM | C_HV | C_OVF | C_UDF, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0);
        step();

        // In-order pops on warp 2 and ready_mask dropping at count 3.
        enq(2, 32'h100); step();
        deq_warp = 2; enq(2, 32'h104);
        chk("w2_after_1", C_RM | C_HV | C_PC, 4'b1111, 4'b0100, 32'h100, 1'b0, 1'b0); step();
        enq(2, 32'h108);
        chk("w2_after_2", C_RM | C_HV | C_PC, 4'b1111, 4'b0100, 32'h100, 1'b0, 1'b0); step();
        chk("w2_after_3", C_RM | C_HV | C_PC, 4'b1011, 4'b0100, 32'h100, 1'b0, 1'b0); step();
        deq(2); chk("w2_pop1", C_PC, 4'b0, 4'b0, 32'h100, 1'b0, 1'b0); step();
        deq(2); chk("w2_pop2", C_PC | C_HV, 4'b0, 4'b0100, 32'h104, 1'b0, 1'b0); step();
        deq(2); chk("w2_pop3", C_PC, 4'b0, 4'b0, 32'h108, 1'b0, 1'b0); step();
        chk("w2_drained", C_RM | C_HV, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0); step();

        // Overflow on full warp 0, then enqueue+dequeue while full.
        deq_warp = 0;
        enq(0, 32'h10); step(); enq(0, 32'h14); step(); enq(0, 32'h18); step(); enq(0, 32'h1C); step();
        enq(0, 32'h20);
        chk("w0_full", C_RM | C_HV | C_PC | C_OVF, 4'b1110, 4'b0001, 32'h10, 1'b0, 1'b0); step();
        enq(0, 32'h24); deq(0);
        chk("w0_ovf", C_RM | C_HV | C_PC | C_OVF, 4'b1110, 4'b0001, 32'h10, 1'b1, 1'b0); step();
        chk("w0_enq_deq_full", C_RM | C_PC | C_OVF, 4'b1110, 4'b0, 32'h14, 1'b1, 1'b0); step();
        deq(0); chk("w0_d1", C_PC, 4'b0, 4'b0, 32'h14, 1'b0, 1'b0); step();
        deq(0); chk("w0_count2", C_RM | C_PC, 4'b1111, 4'b0, 32'h18, 1'b0, 1'b0); step();
        deq(0); chk("w0_d3", C_PC | C_HV, 4'b0, 4'b0001, 32'h1C, 1'b0, 1'b0); step();
        chk("w0_empty", C_HV | C_OVF, 4'b0, 4'b0000, 32'h0, 1'b1, 1'b0); step();

        // Underflow on empty warp 3 leaves other warps alone.
        enq(0, 32'h30); step();
        deq(3); chk("udf_before", C_UDF, 4'b0, 4'b0, 32'h0, 1'b0, 1'b0); step();
        chk("udf_w3", C_RM | C_HV | C_OVF | C_UDF, 4'b1111, 4'b0001, 32'h0, 1'b1, 1'b1); step();

        // Asynchronous reset in the middle of a cycle.
        enq(1, 32'h40); step(); enq(1, 32'h44); step(); enq(1, 32'h48); step();
        deq_warp = 1;
        chk("w1_loaded", C_RM | C_HV | C_PC, 4'b1101, 4'b0011, 32'h40, 1'b0, 1'b0); step();
        reset = 1'b0;
        chk("async_reset", C_RM | C_HV | C_OVF | C_UDF, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b1;
        chk("post_reset", C_RM | C_HV | C_OVF | C_UDF, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0); step();

        // Flush priority over same-cycle enqueue and dequeue.
        enq(1, 32'h50); step(); enq(1, 32'h54); step();
        chk("w1_two", C_RM | C_HV | C_PC, 4'b1111, 4'b0010, 32'h50, 1'b0, 1'b0); step();
        flush_en = 1'b1; flush_warp = 1; enq(1, 32'h58); deq(1); step();
        chk("flush_w1", C_HV | C_OVF | C_UDF, 4'b0, 4'b0000, 32'h0, 1'b0, 1'b0); step();
        flush_en = 1'b1; flush_warp = 1; enq(0, 32'h60); step();
        deq_warp = 0;
        chk("flush_other_enq", C_HV | C_PC, 4'b0, 4'b0001, 32'h60, 1'b0, 1'b0); step();
        enq(1, 32'h64); step();
        deq_warp = 1;
        chk("w1_after_flush", C_HV | C_PC, 4'b0, 4'b0011, 32'h64, 1'b0, 1'b0); step();
        deq(0); step(); deq(1); step();
        chk("clean", C_HV | C_OVF | C_UDF, 4'b0, 4'b0000, 32'h0, 1'b0, 1'b0); step();

        // Enqueue and dequeue of an empty warp in the same cycle.
        enq(2, 32'h200); deq(2);
`ifdef IBUF_BYPASS_EN
        chk("byp_same", C_HV | C_PC, 4'b0, 4'b0100, 32'h200, 1'b0, 1'b0); step();
        chk("byp_after", C_RM | C_HV | C_UDF, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0); step();
`else
        chk("nobyp_same", C_HV | C_UDF, 4'b0, 4'b0000, 32'h0, 1'b0, 1'b0); step();
        deq_warp = 2;
        chk("nobyp_after", C_RM | C_HV | C_PC | C_UDF, 4'b1111, 4'b0100, 32'h200, 1'b0, 1'b1); step();
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/warp_ibuffer.md
Name: warp_ibuffer

Overview:
- Per-warp instruction buffer directly downstream of the fetch stage.
- Accepts fetched instructions tagged with warp ID and PC, and holds them in one FIFO per warp.
- Presents the selected warp's head entry to decode/issue.
- Returns a per-warp ready mask that fetch ANDs into its warp active mask, so it stops selecting warps whose buffer cannot absorb an in-flight fetch.

Parameters:
- NUM_WARPS, 4, warps per SM (matches NUM_WARPS_PER_SM); power of two.
- DEPTH, 4, entries per warp FIFO; power of two, minimum 2.
- PC_WIDTH, 32, PC width.
- INSTR_WIDTH, 32, instruction word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enq_valid  in  1  fetch delivers an instruction this cycle.
- enq_warp  in  log2(NUM_WARPS)  warp ID of the delivered instruction.
- enq_pc  in  PC_WIDTH  PC of the delivered instruction.
- enq_instr  in  INSTR_WIDTH  instruction word.
- ready_mask  out  NUM_WARPS  bit w=1: warp w FIFO has at least 2 free entries.
- deq_warp  in  log2(NUM_WARPS)  warp selected by issue.
- deq_en  in  1  pop head of deq_warp.
- head_valid_mask  out  NUM_WARPS  bit w=1: warp w has a valid head.
- head_pc  out  PC_WIDTH  head PC of deq_warp, combinational.
- head_instr  out  INSTR_WIDTH  head instruction of deq_warp, combinational.
- flush_en  in  1  discard all entries of flush_warp (branch redirect).
- flush_warp  in  log2(NUM_WARPS)  warp to flush.
- overflow  out  1  sticky: enqueue attempted into a full FIFO.
- underflow  out  1  sticky: deq_en asserted on an empty FIFO.

Behaviour:
- Storage and pointers:
  - Each warp has DEPTH entries of {pc, instr}, a read pointer, a write pointer (log2(DEPTH) bits, wrap naturally), and a count (log2(DEPTH)+1 bits).
- Reset (reset low, asynchronous):
  - All pointers and counts are 0.
  - overflow and underflow are 0.
  - ready_mask is all ones; head_valid_mask is all zeros.
  - Entry data is not reset.
- Enqueue:
  - On enq_valid with count[enq_warp] < DEPTH, write at wr_ptr, increment wr_ptr and count.
  - If the FIFO is full, drop the write and set overflow.
  - Enqueue latency: the entry is visible on head outputs the next cycle.
- Dequeue:
  - On deq_en with count[deq_warp] > 0, increment rd_ptr and decrement count.
  - If the FIFO is empty, take no state change and set underflow.
- head_pc and head_instr:
  - Driven by the entry at rd_ptr of deq_warp, every cycle.
  - Contents are undefined when that warp is empty.
- Enqueue and dequeue on the same warp in the same cycle:
  - Both occur and count is unchanged.
  - When the FIFO is full, enqueue is still refused (overflow set) while the dequeue proceeds.
  - When the FIFO is empty, dequeue is underflow; the enqueue proceeds.
- Enqueue and dequeue on different warps: fully independent.
- Flush:
  - flush_en resets rd_ptr, wr_ptr and count of flush_warp to 0 at the next edge.
  - Flush has priority: a same-cycle enqueue to flush_warp is dropped without setting overflow (wrong path).
  - A same-cycle dequeue from flush_warp is ignored without setting underflow.
  - Other warps are unaffected.
- ready_mask[w] = (count[w] <= DEPTH-2), registered-state derived. This covers the one fetch already in flight when ready deasserts.
- head_valid_mask[w] = (count[w] != 0).
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined: when count[deq_warp]==0 and enq_valid with enq_warp==deq_warp (no flush of that warp):
  - head_pc/head_instr are driven combinationally from enq_pc/enq_instr.
  - head_valid_mask[enq_warp] is asserted the same cycle.
  - If deq_en is also asserted that cycle, the entry is consumed without being written: pointers advance together, count stays 0, no underflow.
- Undefined: no enq-to-head path. Minimum latency is 1 cycle, and deq_en on an empty FIFO is underflow even with a same-cycle enqueue.

Test Plan:
- Reset low mid-run with warp 1 holding 3 entries → all pointers and counts are 0 immediately (asynchronous); after release, ready_mask=4'b1111, head_valid_mask=0, overflow=underflow=0.
- Enqueue PCs 0x100,0x104,0x108 to warp 2 on consecutive cycles, then deq_warp=2 with deq_en for 3 cycles → head_pc 0x100,0x104,0x108 in order; head_valid_mask[2] falls after the third pop. ready_mask[2] is 1 after the 1st and 2nd enqueues and falls to 0 on the 3rd enqueue (count=3 > DEPTH-2).
- Fill warp 0 with 4 entries, then a 5th enqueue → overflow=1, count stays 4, head still the first PC. Enqueue plus dequeue on full warp 0 in one cycle → count 3, overflow remains 1.
- deq_en on empty warp 3 → underflow=1, all counts unchanged.
- Warp 1 holds 2 entries; same cycle: flush_warp=1, enq_warp=1, deq_warp=1 with deq_en → count[1]=0, no overflow/underflow. A concurrent enqueue to warp 0 still lands.
- IBUF_BYPASS_EN: warp 2 empty, enq_pc=0x200 with deq_warp=2 and deq_en → head_pc=0x200 the same cycle, count[2] stays 0, no underflow. Without the macro, the same stimulus sets underflow=1 and count[2]=1.
